// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi_lite_pkg : shared states, response codes and PROT default
// Revision     : 1.0
// ============================================================================
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axi_lite_timeout.sv
`default_nettype none
// ============================================================================
// axi_lite_timeout : saturating per-state cycle counter with expiry compare
// Revision         : 1.0
// ============================================================================
module axi_lite_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the cycle that completes TIMEOUT_CYCLES cycles in the state.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    assign expired = 1'b0;
  end else begin : g_timeout
    assign expired = enable && (cnt_q >= CNT_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// axi_lite_master : single-outstanding command-to-AXI4-Lite master
// Revision        : 1.0
// ============================================================================
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  state_e                    state_q,       state_d;
  logic [ADDR_WIDTH-1:0]     addr_q,        addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q,       wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q,       wstrb_d;
  logic                      aw_done_q,     aw_done_d;
  logic                      w_done_q,      w_done_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]                rsp_resp_q,    rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  logic aw_hs;
  logic w_hs;
  logic timeout_hit;
  logic timeout_clear;
  logic timeout_en;

  assign timeout_en = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign timeout_clear = (state_d != state_q);

  axi_lite_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (timeout_clear),
    .enable  (timeout_en),
    .expired (timeout_hit)
  );

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q  || w_hs;
        // Any handshake this cycle takes priority over an expiring counter.
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_RESP;
        end else if (timeout_hit && !aw_hs && !w_hs) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_SLVERR;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_SLVERR;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = ST_RD_DATA;
        end else if (timeout_hit) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_SLVERR;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = ST_RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_SLVERR;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Every channel control is a decode of registered state, so none depends on a READY input.
  assign cmd_ready     = (state_q == ST_IDLE);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = (state_q == ST_WR) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == ST_WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = (state_q == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_RD_DATA);
  assign rsp_valid     = (state_q == ST_RSP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_master : directed bench with a reactive slave and a response model
// Revision           : 1.0
// ============================================================================
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reactive slave ----------------
  int   aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit   ar_never = 0, b_hold = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] slave_mem [0:63];
  int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int   last_ar_run = 0;
  logic [31:0] got_addr, got_wdata;
  logic [3:0]  got_strb;

  initial begin
    bit aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, txn_aw, txn_w;
    logic [31:0] aw_pa, w_pd, ar_pa;
    logic [3:0]  w_ps;
    int aw_wait, w_wait, ar_wait, ar_run;
    for (int i = 0; i < 64; i++) slave_mem[i] = 32'h0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
    aw_got = 0; w_got = 0; txn_aw = 0; txn_w = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; ar_run = 0;
    aw_pa = 0; w_pd = 0; ar_pa = 0; w_ps = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
        aw_got = 0; w_got = 0; txn_aw = 0; txn_w = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; ar_run = 0;
        continue;
      end
      // account for handshakes that completed at the last rising edge
      if (aw_pend) begin aw_cnt++; aw_got = 1; txn_aw = 1; got_addr = aw_pa; aw_wait = 0; end
      if (w_pend)  begin w_cnt++;  w_got = 1;  txn_w = 1;  got_wdata = w_pd; got_strb = w_ps; w_wait = 0; end
      if (b_pend)  begin b_cnt++;  bvalid = 0; txn_aw = 0; txn_w = 0; end
      if (r_pend)  begin r_cnt++;  rvalid = 0; end
      if (ar_pend) begin
        ar_cnt++; ar_wait = 0;
        rvalid = 1; rdata = slave_mem[ar_pa[7:2]]; rresp = rresp_cfg;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (got_strb[b]) slave_mem[got_addr[7:2]][8*b +: 8] = got_wdata[8*b +: 8];
        aw_got = 0; w_got = 0;
        if (!b_hold) begin bvalid = 1; bresp = bresp_cfg; end
      end
      if (bready) chk("bready_after_aw_and_w", {txn_aw, txn_w}, 2'b11);
      awready = awvalid && (aw_wait >= aw_delay);
      if (awvalid && !awready) aw_wait++;
      wready = wvalid && (w_wait >= w_delay);
      if (wvalid && !wready) w_wait++;
      arready = arvalid && !ar_never && (ar_wait >= ar_delay);
      if (arvalid && !arready) ar_wait++;
      if (arvalid) ar_run++;
      else if (ar_run != 0) begin last_ar_run = ar_run; ar_run = 0; end
      aw_pend = awvalid && awready; aw_pa = awaddr;
      w_pend  = wvalid && wready;   w_pd = wdata; w_ps = wstrb;
      b_pend  = bvalid && bready;
      ar_pend = arvalid && arready; ar_pa = araddr;
      r_pend  = rvalid && rready;
    end
  end

  // ---------------- response model and per-cycle compare ----------------
  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:63];

  initial begin
    bit pv, paw, pw, par;
    logic [31:0] paw_a, par_a, pw_d;
    logic [3:0]  pw_s;
    pv = 0; paw = 0; pw = 0; par = 0; paw_a = 0; par_a = 0; pw_d = 0; pw_s = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin pv = 0; paw = 0; pw = 0; par = 0; continue; end
      if (pv && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rsp_valid) begin
        chk("rsp_has_expectation", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_resp", rsp_resp, exp_q[0].resp);
          chk("rsp_timeout", rsp_timeout, exp_q[0].to);
        end
        chk("cmd_ready_low_while_rsp", cmd_ready, 0);
      end
      if (!(rsp_valid && rsp_timeout)) begin
        if (paw && !awready) begin chk("awvalid_held", awvalid, 1); chk("awaddr_stable", awaddr, paw_a); end
        if (pw && !wready) begin
          chk("wvalid_held", wvalid, 1); chk("wdata_stable", wdata, pw_d); chk("wstrb_stable", wstrb, pw_s);
        end
        if (par && !arready) begin chk("arvalid_held", arvalid, 1); chk("araddr_stable", araddr, par_a); end
      end
      pv = rsp_valid; paw = awvalid; pw = wvalid; par = arvalid;
      paw_a = awaddr; par_a = araddr; pw_d = wdata; pw_s = wstrb;
    end
  end

  // ---------------- command driver ----------------
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;
  logic        last_to;
  int          last_lat;

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input exp_t e);
    int n;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("cmd_accept_bound", n, 0);
    @(negedge clk);
    cmd_valid = 0;
    last_lat = 1;
    while (!rsp_valid && last_lat < 200) begin @(negedge clk); last_lat++; end
    if (!rsp_valid) chk("rsp_arrival_bound", last_lat, 0);
    last_rdata = rsp_rdata; last_resp = rsp_resp; last_to = rsp_timeout;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input bit expect_timeout);
    exp_t e;
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
    e.rdata = 32'h0;
    e.resp  = expect_timeout ? 2'b10 : bresp_cfg;
    e.to    = expect_timeout;
    run_cmd(1'b1, addr, data, strb, 0, e);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, input bit expect_timeout);
    exp_t e;
    e.rdata = expect_timeout ? 32'h0 : ref_mem[addr[7:2]];
    e.resp  = expect_timeout ? 2'b10 : rresp_cfg;
    e.to    = expect_timeout;
    run_cmd(1'b0, addr, 32'h0, 4'h0, hold, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);   chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_arvalid"}, arvalid, 0);   chk({tag, "_bready"}, bready, 0);
    chk({tag, "_rready"}, rready, 0);     chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0); chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_awaddr"}, awaddr, 0);     chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, b0, ar0, r0, n;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("prot_zero", {awprot, arprot}, 6'b0);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Zero-wait write, then read it back
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_write(32'h8, 32'hA5A5_0001, 4'hF, 0);
    chk("wr_latency", last_lat, 3);
    chk("wr_resp", last_resp, 2'b00);
    chk("wr_timeout", last_to, 0);
    chk("wr_aw_count", aw_cnt - a0, 1);
    chk("wr_w_count", w_cnt - w0, 1);
    chk("wr_b_count", b_cnt - b0, 1);
    chk("wr_awaddr_seen", got_addr, 32'h8);
    chk("wr_wdata_seen", got_wdata, 32'hA5A5_0001);
    chk("wr_wstrb_seen", got_strb, 4'hF);
    do_read(32'h8, 0, 0);
    chk("rd_latency", last_lat, 3);
    chk("rd_data", last_rdata, 32'hA5A5_0001);

    // W completes four cycles ahead of AW
    aw_delay = 4; a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_write(32'h10, 32'h0000_1234, 4'hF, 0);
    aw_delay = 0;
    chk("skew_aw_count", aw_cnt - a0, 1);
    chk("skew_w_count", w_cnt - w0, 1);
    chk("skew_b_count", b_cnt - b0, 1);
    chk("skew_latency", last_lat, 7);
    chk("skew_no_extra_rsp", exp_q.size(), 0);

    // Six writes then six reads
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    for (int i = 0; i < 6; i++) do_write(32'(i * 4), 32'(i), 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      do_read(32'(i * 4), 0, 0);
      chk("seq_rdata", last_rdata, 32'(i));
    end
    chk("seq_aw_count", aw_cnt - a0, 6);
    chk("seq_w_count", w_cnt - w0, 6);
    chk("seq_b_count", b_cnt - b0, 6);
    chk("seq_ar_count", ar_cnt - ar0, 6);
    chk("seq_r_count", r_cnt - r0, 6);

    // Byte strobes merge into the existing word
    do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0);
    do_write(32'h20, 32'h1122_3344, 4'h5, 0);
    do_read(32'h20, 0, 0);
    chk("strobe_merge", last_rdata, 32'hFF22_FF44);

    // Non-OKAY responses, response held under backpressure
    bresp_cfg = 2'b01;
    do_write(32'h24, 32'hCAFE_0000, 4'hF, 0);
    chk("bresp_exokay", last_resp, 2'b01);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    do_read(32'h4, 5, 0);
    chk("rresp_decerr", last_resp, 2'b11);
    chk("rresp_data", last_rdata, 32'h1);
    rresp_cfg = 2'b00;

    // Read address never accepted
    ar_never = 1; ar0 = ar_cnt; r0 = r_cnt;
    do_read(32'h0, 0, 1);
    ar_never = 0;
    chk("ar_timeout_flag", last_to, 1);
    chk("ar_timeout_resp", last_resp, 2'b10);
    chk("ar_timeout_rdata", last_rdata, 0);
    chk("ar_timeout_latency", last_lat, 17);
    chk("ar_valid_cycles", last_ar_run, 16);
    chk("ar_timeout_ar_count", ar_cnt - ar0, 0);
    chk("ar_timeout_r_count", r_cnt - r0, 0);

    // Write response never returned
    b_hold = 1; b0 = b_cnt;
    do_write(32'h30, 32'h0BAD_0BAD, 4'hF, 1);
    chk("b_timeout_flag", last_to, 1);
    chk("b_timeout_resp", last_resp, 2'b10);
    chk("b_timeout_latency", last_lat, 18);
    chk("b_timeout_b_count", b_cnt - b0, 0);

    // Reset while waiting in WR_RESP
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h34; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    chk("reached_wr_resp", bready, 1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1; b_hold = 0;
    @(negedge clk);
    chk("cmd_ready_after_midreset", cmd_ready, 1);
    b0 = b_cnt;
    do_write(32'h38, 32'h0000_0077, 4'hF, 0);
    chk("post_reset_latency", last_lat, 3);
    chk("post_reset_resp", last_resp, 2'b00);
    chk("post_reset_b_count", b_cnt - b0, 1);
    do_read(32'h38, 0, 0);
    chk("post_reset_rdata", last_rdata, 32'h77);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_WIDTH, 32, AXI address width in bits.
REQ-002 Parameter DATA_WIDTH, 32, data width in bits; legal values are 32 and 64.
REQ-003 Parameter TIMEOUT_CYCLES, 256, cycles to wait for a slave handshake before abort; 0 disables the timeout.
REQ-004 Port M_AXI_ACLK, in, 1: the single clock.
REQ-005 Port M_AXI_ARESETN, in, 1: synchronous, active-low reset.
REQ-006 Command ports, all in: cmd_valid (1), cmd_write (1), cmd_addr (ADDR_WIDTH), cmd_wdata (DATA_WIDTH), cmd_wstrb (DATA_WIDTH/8).
REQ-007 Port cmd_ready, out, 1: the block accepts the command when cmd_valid and cmd_ready are both high.
REQ-008 Response ports, all out: rsp_valid (1), rsp_rdata (DATA_WIDTH), rsp_resp (2), rsp_timeout (1).
REQ-009 Port rsp_ready, in, 1: response handshake input.
REQ-010 AXI4-Lite master channel ports: M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY; widths per the parameters.

Function
REQ-011 States: IDLE, WR (AW and W in flight), WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-012 cmd_ready is high only in IDLE; on acceptance, all command fields are registered and the FSM moves to WR or RD_ADDR on the next edge.
REQ-013 In WR, AWVALID and WVALID assert in the same cycle; each channel deasserts independently on its own handshake; AW-before-W, W-before-AW and simultaneous completion are all legal.
REQ-014 WR moves to WR_RESP only after both AW and W have completed; BREADY is high throughout WR_RESP.
REQ-015 RD_ADDR holds ARVALID until ARREADY, then moves to RD_DATA with RREADY high until RVALID.
REQ-016 AWVALID, WVALID and ARVALID, once raised, stay high with address, data and strobes stable until their handshake (AXI rule); they do not depend on READY.
REQ-017 On B or R handshake: capture BRESP/RRESP into rsp_resp; capture RDATA into rsp_rdata (reads); rsp_rdata = 0 for writes; enter RSP.
REQ-018 RSP holds rsp_valid high with stable fields until rsp_ready, then returns to IDLE.
REQ-019 Minimum latency, acceptance to rsp_valid, with zero-wait slave: 3 cycles for a write, 3 cycles for a read.
REQ-020 AWPROT = ARPROT = 3'b000 constant.
REQ-021 Timeout counter: clears on every state entry, increments each cycle in WR, WR_RESP, RD_ADDR and RD_DATA, and saturates.
REQ-022 When the counter reaches TIMEOUT_CYCLES: drop all xVALID/xREADY, set rsp_timeout = 1, set rsp_resp = 2'b10 (SLVERR), enter RSP.
REQ-023 A timeout and a handshake occurring in the same cycle: the handshake wins and no timeout is flagged.
REQ-024 Back-to-back commands: the next cmd_ready is no earlier than the cycle after the rsp handshake; one transaction is outstanding at most.

Reset
REQ-025 While M_AXI_ARESETN is low at a clock edge: state = IDLE, all VALID/READY outputs = 0, rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0, counter = 0, address/data registers = 0.
REQ-026 Reset mid-transaction aborts with no response produced; cmd_ready = 1 on the first cycle after reset is released.

Structure
REQ-027 The shared package axi_lite_pkg holds: the state enumeration, the RESP codes (OKAY 0, EXOKAY 1, SLVERR 2, DECERR 3), and the PROT default.
REQ-028 The design is a single module except for the natural sub-module axi_lite_timeout, which contains the counter and compare.

Verification
REQ-029 Write addr 0x8, data 0xA5A5_0001, wstrb 0xF, zero-wait slave -> one AW and one W handshake; rsp_valid after 3 cycles with rsp_resp = 0, rsp_timeout = 0.
REQ-030 Slave asserts WREADY 4 cycles before AWREADY -> BREADY is not raised until both complete; exactly one response.
REQ-031 Six writes to addresses 0x0..0x14 with data addr/4, then six reads -> rsp_rdata returns 0..5 in order; each AXI channel shows one handshake per command.
REQ-032 TIMEOUT_CYCLES = 16, slave never raises ARREADY -> ARVALID drops at cycle 16; rsp_timeout = 1 and rsp_resp = 2 are reported.
REQ-033 Slave returns RRESP = 3 with rsp_ready held low for 5 cycles -> rsp fields stay stable and cmd_ready stays low until the rsp handshake.
REQ-034 Reset asserted while in WR_RESP -> all outputs are at reset values on the next edge; no rsp_valid; a new command is accepted after release.
